sd_dev_cmd_layer: RTL and testbench
===================================

SD_DEV_CMD_LAYER -- requirements
Module: sd_dev_cmd_layer

Interface
REQ-001 SHALL have parameter NCR_MIN, default 2: minimum phy clock periods from command end bit to response start bit.
REQ-002 SHALL have parameter NCR_MAX, default 64: maximum phy clock periods spent waiting for i_rsp_stb before abandoning the response.
REQ-003 SHALL have port clk, input, 1: system clock; the single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_locked, input, 1: platform ready; command reception is ignored while low.
REQ-006 SHALL have port i_phy_clk, input, 1: SD bus clock as seen by the platform.
REQ-007 SHALL have port i_sd_cmd_in, input, 1: CMD line value from the platform.
REQ-008 SHALL have port o_sd_cmd_dir, output, 1: 1 = drive CMD line.
REQ-009 SHALL have port o_sd_cmd_out, output, 1: CMD line drive value.
REQ-010 SHALL have port o_cmd_stb, output, 1: one-clk pulse, received command valid.
REQ-011 SHALL have ports o_cmd_index (output, 6), o_cmd_arg (output, 32), o_cmd_crc_err (output, 1) and o_cmd_frame_err (output, 1): command fields, held until the next o_cmd_stb.
REQ-012 SHALL have ports i_rsp_stb (input, 1), i_rsp_index (input, 6) and i_rsp_arg (input, 32): response request and its fields.
REQ-013 SHALL have ports o_rsp_busy (output, 1), o_rsp_done (output, 1, pulse) and o_rsp_timeout (output, 1, pulse).

Function
REQ-014 SHALL register i_phy_clk once and generate one-clk strobes: rise (cur=1, prev=0) and fall (cur=0, prev=1).
REQ-015 SHALL sample i_sd_cmd_in only on rise strobes and change o_sd_cmd_out/o_sd_cmd_dir only on fall strobes.
REQ-016 SHALL implement states IDLE, RX, RSP_WAIT, RSP_PAD, TX and TX_END.
REQ-017 IDLE: on a rise with i_locked=1 and i_sd_cmd_in=0 (start bit), SHALL go to RX with bit count 1.
REQ-018 RX: SHALL shift in bits 46..0 (47 further samples), MSB first; after the 48th bit SHALL pulse o_cmd_stb on the next clk.
REQ-019 CRC7: polynomial x^7+x^3+1, initial value 0, computed over frame bits 47..8; o_cmd_crc_err=1 if it differs from bits 7..1.
REQ-020 o_cmd_frame_err=1 if the transmission bit (46) is not 1 or the end bit (0) is not 1.
REQ-021 After the strobe, SHALL go to RSP_WAIT if both error flags are 0, else to IDLE (no response for bad commands).
REQ-022 RSP_WAIT: SHALL accept i_rsp_stb and latch index/arg, then go to RSP_PAD; i_rsp_stb SHALL be ignored in all other states.
REQ-023 If NCR_MAX rise strobes after the end bit pass with no i_rsp_stb, SHALL pulse o_rsp_timeout and go to IDLE.
REQ-024 RSP_PAD: SHALL wait until at least NCR_MIN rise strobes have passed since the end bit, then go to TX at the next fall.
REQ-025 TX: SHALL assert o_sd_cmd_dir and shift out 48 bits, one per fall, MSB first: 0, 0, index[5:0], arg[31:0], CRC7 computed over those 40 bits, 1.
REQ-026 TX_END: on the fall after the end bit, SHALL set o_sd_cmd_dir=0 and o_sd_cmd_out=1, pulse o_rsp_done, and return to IDLE.
REQ-027 o_rsp_busy SHALL be 1 in RSP_PAD, TX and TX_END, and 0 otherwise.
REQ-028 SHALL never start receiving while o_sd_cmd_dir=1; a start bit in RSP_WAIT or RSP_PAD SHALL be ignored.
REQ-029 If i_locked falls during RX, SHALL abort to IDLE without asserting o_cmd_stb.
REQ-030 A rise and a fall can never occur on the same clk; no simultaneous-edge handling is required.

Reset
REQ-031 rst high SHALL immediately force IDLE, o_sd_cmd_dir=0, o_sd_cmd_out=1, all strobes 0, o_rsp_busy=0, o_cmd_index=0, o_cmd_arg=0 and both error flags 0.
REQ-032 Reset mid-TX SHALL release the CMD line in the same instant, with no clk edge needed.
REQ-033 After rst deasserts, the edge-detect register SHALL load before the first strobe, so no spurious strobe is generated.

Verification
REQ-034 CMD0 frame 0x40_00000000_95 -> o_cmd_stb, index=0, arg=0, crc_err=0, frame_err=0.
REQ-035 CMD8 frame 0x48_000001AA_87, then i_rsp_stb with index=8, arg=0x000001AA -> TX frame 0x08_000001AA_13; dir high for exactly 48 phy clocks, start bit no earlier than 2 phy clocks after the command end bit.
REQ-036 CMD8 sent with CRC byte 0x85 -> crc_err=1, no response, state IDLE.
REQ-037 Valid command with no i_rsp_stb -> o_rsp_timeout after 64 phy clocks; CMD line never driven.
REQ-038 rst asserted at TX bit 20 -> o_sd_cmd_dir=0 asynchronously; the next command is received correctly.
REQ-039 Start bit while i_locked=0, and i_locked dropped mid-RX -> no o_cmd_stb.

Source files
------------

// File: rtl/sd_dev_cmd_layer.sv
// SD device command layer: receives 48-bit host commands on the CMD line
// and transmits a 48-bit response frame after the host requests one.
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   i_locked                  platform ready, gates command reception
//   i_phy_clk                 SD bus clock, edge-detected on clk
//   i_sd_cmd_in               CMD line input, sampled on phy rise
//   o_sd_cmd_dir/o_sd_cmd_out CMD line drive enable/value, updated on phy fall
//   o_cmd_stb                 one-clk pulse, command fields valid
//   o_cmd_index/o_cmd_arg     received command fields (held)
//   o_cmd_crc_err             CRC7 mismatch on the last command
//   o_cmd_frame_err           bad transmission or end bit on the last command
//   i_rsp_stb/i_rsp_index/i_rsp_arg  response request and fields
//   o_rsp_busy                response pending or being sent
//   o_rsp_done                one-clk pulse, response end bit sent
//   o_rsp_timeout             one-clk pulse, no response request in time
module sd_dev_cmd_layer #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_locked,
  input  logic        i_phy_clk,
  input  logic        i_sd_cmd_in,
  output logic        o_sd_cmd_dir,
  output logic        o_sd_cmd_out,
  output logic        o_cmd_stb,
  output logic [5:0]  o_cmd_index,
  output logic [31:0] o_cmd_arg,
  output logic        o_cmd_crc_err,
  output logic        o_cmd_frame_err,
  input  logic        i_rsp_stb,
  input  logic [5:0]  i_rsp_index,
  input  logic [31:0] i_rsp_arg,
  output logic        o_rsp_busy,
  output logic        o_rsp_done,
  output logic        o_rsp_timeout
);

  localparam int CW = $clog2(NCR_MAX + 1) + 1;
  localparam logic [CW-1:0] NCR_MAX_M1 = CW'(NCR_MAX - 1);
  localparam logic [CW-1:0] NCR_MIN_C  = CW'(NCR_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_RSP_WAIT,
    S_RSP_PAD,
    S_TX,
    S_TX_END
  } state_t;

  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t        r_state, w_state;
  logic          r_phy_prev;
  logic          r_init;
  logic [5:0]    r_bitcnt, w_bitcnt;
  logic [47:0]   r_sr, w_sr;
  logic          r_rx_done, w_rx_done;
  logic [CW-1:0] r_ncr, w_ncr;
  logic [47:0]   r_tx_sr, w_tx_sr;
  logic          r_dir, w_dir;
  logic          r_out, w_out;
  logic          r_cmd_stb, w_cmd_stb;
  logic [5:0]    r_cmd_index, w_cmd_index;
  logic [31:0]   r_cmd_arg, w_cmd_arg;
  logic          r_crc_err, w_crc_err;
  logic          r_frame_err, w_frame_err;
  logic          r_rsp_done, w_rsp_done;
  logic          r_rsp_to, w_rsp_to;

  logic          w_rise, w_fall;
  logic [CW-1:0] w_ncr_inc;
  logic [6:0]    w_rx_crc;
  logic [39:0]   w_tx_body;
  logic          w_crc_bad, w_frm_bad;

  // r_init holds strobes off until r_phy_prev has seen the real clock level
  assign w_rise = r_init & i_phy_clk & ~r_phy_prev;
  assign w_fall = r_init & ~i_phy_clk & r_phy_prev;

  // rise count since the command end bit, saturating
  assign w_ncr_inc = (&r_ncr) ? r_ncr : r_ncr + 1'b1;

  assign w_rx_crc  = f_crc7(r_sr[47:8]);
  assign w_crc_bad = (w_rx_crc != r_sr[7:1]);
  assign w_frm_bad = ~r_sr[46] | ~r_sr[0];
  assign w_tx_body = {2'b00, i_rsp_index, i_rsp_arg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phy_prev  <= 1'b0;
      r_init      <= 1'b0;
      r_bitcnt    <= '0;
      r_sr        <= '0;
      r_rx_done   <= 1'b0;
      r_ncr       <= '0;
      r_tx_sr     <= '1;
      r_dir       <= 1'b0;
      r_out       <= 1'b1;
      r_cmd_stb   <= 1'b0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rsp_done  <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_phy_prev  <= i_phy_clk;
      r_init      <= 1'b1;
      r_bitcnt    <= w_bitcnt;
      r_sr        <= w_sr;
      r_rx_done   <= w_rx_done;
      r_ncr       <= w_ncr;
      r_tx_sr     <= w_tx_sr;
      r_dir       <= w_dir;
      r_out       <= w_out;
      r_cmd_stb   <= w_cmd_stb;
      r_cmd_index <= w_cmd_index;
      r_cmd_arg   <= w_cmd_arg;
      r_crc_err   <= w_crc_err;
      r_frame_err <= w_frame_err;
      r_rsp_done  <= w_rsp_done;
      r_rsp_to    <= w_rsp_to;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_bitcnt    = r_bitcnt;
    w_sr        = r_sr;
    w_rx_done   = r_rx_done;
    w_ncr       = r_ncr;
    w_tx_sr     = r_tx_sr;
    w_dir       = r_dir;
    w_out       = r_out;
    w_cmd_stb   = 1'b0;
    w_cmd_index = r_cmd_index;
    w_cmd_arg   = r_cmd_arg;
    w_crc_err   = r_crc_err;
    w_frame_err = r_frame_err;
    w_rsp_done  = 1'b0;
    w_rsp_to    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise && i_locked && !i_sd_cmd_in) begin
          w_state   = S_RX;
          w_bitcnt  = 6'd1;
          w_sr      = '0;
          w_rx_done = 1'b0;
        end
      end
      S_RX: begin
        if (!i_locked) begin
          w_state = S_IDLE;
        end else if (r_rx_done) begin
          w_cmd_stb   = 1'b1;
          w_cmd_index = r_sr[45:40];
          w_cmd_arg   = r_sr[39:8];
          w_crc_err   = w_crc_bad;
          w_frame_err = w_frm_bad;
          w_state     = (w_crc_bad || w_frm_bad) ? S_IDLE : S_RSP_WAIT;
        end else if (w_rise) begin
          w_sr     = {r_sr[46:0], i_sd_cmd_in};
          w_bitcnt = r_bitcnt + 6'd1;
          if (r_bitcnt == 6'd47) begin
            w_rx_done = 1'b1;
            w_ncr     = '0;
          end
        end
      end
      S_RSP_WAIT: begin
        if (i_rsp_stb) begin
          w_tx_sr = {w_tx_body, f_crc7(w_tx_body), 1'b1};
          w_state = S_RSP_PAD;
          if (w_rise) w_ncr = w_ncr_inc;
        end else if (w_rise) begin
          if (r_ncr == NCR_MAX_M1) begin
            w_rsp_to = 1'b1;
            w_state  = S_IDLE;
          end else begin
            w_ncr = w_ncr_inc;
          end
        end
      end
      S_RSP_PAD: begin
        if (w_rise) w_ncr = w_ncr_inc;
        if (w_fall && r_ncr >= NCR_MIN_C) begin
          w_state  = S_TX;
          w_dir    = 1'b1;
          w_out    = r_tx_sr[47];
          w_tx_sr  = {r_tx_sr[46:0], 1'b1};
          w_bitcnt = 6'd1;
        end
      end
      S_TX: begin
        if (w_fall) begin
          w_out    = r_tx_sr[47];
          w_tx_sr  = {r_tx_sr[46:0], 1'b1};
          w_bitcnt = r_bitcnt + 6'd1;
          if (r_bitcnt == 6'd47) w_state = S_TX_END;
        end
      end
      S_TX_END: begin
        if (w_fall) begin
          w_dir      = 1'b0;
          w_out      = 1'b1;
          w_rsp_done = 1'b1;
          w_state    = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign o_sd_cmd_dir    = r_dir;
  assign o_sd_cmd_out    = r_out;
  assign o_cmd_stb       = r_cmd_stb;
  assign o_cmd_index     = r_cmd_index;
  assign o_cmd_arg       = r_cmd_arg;
  assign o_cmd_crc_err   = r_crc_err;
  assign o_cmd_frame_err = r_frame_err;
  assign o_rsp_done      = r_rsp_done;
  assign o_rsp_timeout   = r_rsp_to;
  assign o_rsp_busy      = (r_state == S_RSP_PAD) ||
                           (r_state == S_TX) ||
                           (r_state == S_TX_END);

endmodule

// File: tb/tb_sd_dev_cmd_layer.sv
// Testbench for sd_dev_cmd_layer: acts as SD host on the CMD line and
// compares DUT behaviour against a frame/CRC model built from polynomial division.
module tb_sd_dev_cmd_layer;

  localparam int NCR_MIN = 2;
  localparam int NCR_MAX = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b0;
  logic        phy = 1'b0;
  logic        cmd_in = 1'b1;
  logic        rsp_stb = 1'b0;
  logic [5:0]  rsp_idx = '0;
  logic [31:0] rsp_arg = '0;

  logic        dir, out, cmd_stb, crc_err, frm_err;
  logic        busy, done, tmo;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;

  sd_dev_cmd_layer #(.NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
    .clk(clk), .rst(rst), .i_locked(locked), .i_phy_clk(phy),
    .i_sd_cmd_in(cmd_in), .o_sd_cmd_dir(dir), .o_sd_cmd_out(out),
    .o_cmd_stb(cmd_stb), .o_cmd_index(cmd_idx), .o_cmd_arg(cmd_arg),
    .o_cmd_crc_err(crc_err), .o_cmd_frame_err(frm_err),
    .i_rsp_stb(rsp_stb), .i_rsp_index(rsp_idx), .i_rsp_arg(rsp_arg),
    .o_rsp_busy(busy), .o_rsp_done(done), .o_rsp_timeout(tmo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt = 0, done_cnt = 0, to_cnt = 0, to_n = 0;
  int phy_n = 0, dir_cyc = 0, first_n = 0, end_n = 0;
  logic [47:0] txf = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_stb) stb_cnt++;
      if (done) done_cnt++;
      if (tmo) begin
        to_cnt++;
        to_n = phy_n;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // CRC7 as remainder of (data * x^7) mod (x^7+x^3+1)
  function automatic logic [6:0] m_crc(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int b = 46; b >= 7; b--)
      if (v[b]) v = v ^ (47'h89 << (b - 7));
    return v[6:0];
  endfunction

  function automatic logic [47:0] mk(input logic [5:0] idx,
                                     input logic [31:0] arg,
                                     input logic txb);
    logic [39:0] body;
    body = {1'b0, txb, idx, arg};
    return {body, m_crc(body), 1'b1};
  endfunction

  // one phy period; host drives on fall, samples line just before rise
  task automatic phy_cycle(input logic v);
    logic line;
    @(negedge clk);
    phy = 1'b0;
    cmd_in = v;
    repeat (3) @(negedge clk);
    line = dir ? out : 1'b1;
    if (dir) begin
      if (dir_cyc == 0) first_n = phy_n + 1;
      dir_cyc++;
      txf = {txf[46:0], line};
    end
    @(negedge clk);
    phy = 1'b1;
    phy_n++;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) phy_cycle(1'b1);
  endtask

  task automatic send(input logic [47:0] f, input int drop);
    for (int i = 47; i >= 0; i--) begin
      if (i == drop) locked = 1'b0;
      phy_cycle(f[i]);
    end
    end_n = phy_n;
  endtask

  task automatic respond(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge clk);
    rsp_idx = idx;
    rsp_arg = arg;
    rsp_stb = 1'b1;
    @(negedge clk);
    rsp_stb = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [47:0] f;
    logic        lk;
    int          drop;
    logic        e_stb;
    logic [5:0]  e_idx;
    logic [31:0] e_arg;
    logic        e_crc;
    logic        e_frm;
    logic        e_to;
  } vec_t;

  vec_t tv[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int s0, d0, t0, k;
    logic [47:0] f;
    logic [5:0]  ix, rix;
    logic [31:0] ag, rag;
    logic        ecrc, efrm;
    int          mode, dly;

    tv.push_back('{"cmd0", 48'h40_0000_0000_95, 1, -1, 1, 6'd0, 32'h0, 0, 0, 1});
    tv.push_back('{"cmd8", 48'h48_0000_01AA_87, 1, -1, 1, 6'd8, 32'h1AA, 0, 0, 1});
    tv.push_back('{"cmd8_badcrc", 48'h48_0000_01AA_85, 1, -1, 1, 6'd8, 32'h1AA, 1, 0, 0});
    tv.push_back('{"txbit0", mk(6'd17, 32'h1234, 1'b0), 1, -1, 1, 6'd17, 32'h1234, 0, 1, 0});
    tv.push_back('{"endbit0", mk(6'd55, 32'hDEADBEEF, 1'b1) & ~48'h1, 1, -1, 1, 6'd55, 32'hDEADBEEF, 0, 1, 0});
    tv.push_back('{"unlocked", 48'h40_0000_0000_95, 0, -1, 0, 6'd0, 32'h0, 0, 0, 0});
    tv.push_back('{"lockdrop", 48'h40_0000_0000_95, 1, 20, 0, 6'd0, 32'h0, 0, 0, 0});

    // reset with phy high and line low: no spurious strobe allowed
    rst = 1'b1; phy = 1'b1; cmd_in = 1'b0; locked = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dir", dir, 0);
    chk("rst_out", out, 1);
    chk("rst_stb", cmd_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", cmd_idx, 0);
    chk("rst_arg", cmd_arg, 0);
    chk("rst_errs", {crc_err, frm_err, done, tmo}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    s0 = stb_cnt;
    idle(60);
    chk("no_spurious_stb", stb_cnt - s0, 0);

    foreach (tv[i]) begin
      locked = tv[i].lk;
      dir_cyc = 0;
      s0 = stb_cnt; t0 = to_cnt;
      send(tv[i].f, tv[i].drop);
      idle(2);
      chk({tv[i].name, "_stb"}, stb_cnt - s0, tv[i].e_stb);
      if (tv[i].e_stb) begin
        chk({tv[i].name, "_idx"}, cmd_idx, tv[i].e_idx);
        chk({tv[i].name, "_arg"}, cmd_arg, tv[i].e_arg);
        chk({tv[i].name, "_crc"}, crc_err, tv[i].e_crc);
        chk({tv[i].name, "_frm"}, frm_err, tv[i].e_frm);
      end
      locked = 1'b1;
      idle(NCR_MAX + 8);
      chk({tv[i].name, "_to"}, to_cnt - t0, tv[i].e_to);
      if (tv[i].e_to)
        chk({tv[i].name, "_to_lat"}, to_n - end_n, NCR_MAX);
      chk({tv[i].name, "_nodrive"}, dir_cyc, 0);
      chk({tv[i].name, "_busy"}, busy, 0);
    end

    // CMD8 with response
    dir_cyc = 0; d0 = done_cnt;
    send(48'h48_0000_01AA_87, -1);
    idle(1);
    respond(6'd8, 32'h1AA);
    idle(60);
    chk("cmd8_rsp_frame", txf, 48'h08_0000_01AA_13);
    chk("cmd8_rsp_len", dir_cyc, 48);
    chk("cmd8_rsp_done", done_cnt - d0, 1);
    chk("cmd8_ncr_min", (first_n - end_n) >= NCR_MIN, 1);
    chk("cmd8_busy_end", busy, 0);

    // start bit during RSP_WAIT is ignored; response still goes out
    dir_cyc = 0; d0 = done_cnt;
    send(48'h40_0000_0000_95, -1);
    s0 = stb_cnt;
    send(mk(6'd1, 32'hFFFF, 1'b1), -1);
    chk("wait_ignore_stb", stb_cnt - s0, 0);
    respond(6'd3, 32'hA5A5_0000);
    idle(60);
    chk("wait_rsp_frame", txf, mk(6'd3, 32'hA5A5_0000, 1'b0));
    chk("wait_rsp_len", dir_cyc, 48);
    chk("wait_rsp_done", done_cnt - d0, 1);

    // reset in the middle of a response
    dir_cyc = 0;
    send(48'h48_0000_01AA_87, -1);
    respond(6'd8, 32'h1AA);
    k = 0;
    while (dir_cyc < 20 && k < 100) begin
      phy_cycle(1'b1);
      k++;
    end
    chk("midtx_reached", dir_cyc >= 20, 1);
    chk("midtx_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midtx_rst_dir", dir, 0);
    chk("midtx_rst_out", out, 1);
    chk("midtx_rst_busy", busy, 0);
    chk("midtx_rst_idx", cmd_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    s0 = stb_cnt;
    send(mk(6'd17, 32'hCAFE, 1'b1), -1);
    idle(2);
    chk("postrst_stb", stb_cnt - s0, 1);
    chk("postrst_idx", cmd_idx, 17);
    chk("postrst_arg", cmd_arg, 32'hCAFE);
    idle(NCR_MAX + 4);

    // randomized commands against the model
    for (int r = 0; r < 10; r++) begin
      ix = 6'($urandom_range(0, 63));
      ag = $urandom;
      mode = $urandom_range(0, 4);
      f = mk(ix, ag, 1'b1);
      if (mode == 3) f = f ^ (48'h2 << $urandom_range(0, 6));
      if (mode == 4) f = f & ~48'h1;
      ecrc = (f[7:1] != m_crc(f[47:8]));
      efrm = !f[46] || !f[0];
      dir_cyc = 0; s0 = stb_cnt; d0 = done_cnt; t0 = to_cnt;
      send(f, -1);
      chk("rnd_stb", stb_cnt - s0, 1);
      chk("rnd_idx", cmd_idx, ix);
      chk("rnd_arg", cmd_arg, ag);
      chk("rnd_crc", crc_err, ecrc);
      chk("rnd_frm", frm_err, efrm);
      if (mode <= 1) begin
        dly = $urandom_range(0, 30);
        rix = 6'($urandom_range(0, 63));
        rag = $urandom;
        idle(dly);
        respond(rix, rag);
        idle(60);
        chk("rnd_rsp_frame", txf, mk(rix, rag, 1'b0));
        chk("rnd_rsp_len", dir_cyc, 48);
        chk("rnd_rsp_done", done_cnt - d0, 1);
        chk("rnd_ncr", (first_n - end_n) >= NCR_MIN, 1);
        chk("rnd_to_none", to_cnt - t0, 0);
      end else begin
        idle(NCR_MAX + 8);
        chk("rnd_to", to_cnt - t0, (mode == 2) ? 1 : 0);
        chk("rnd_nodrive", dir_cyc, 0);
        chk("rnd_nodone", done_cnt - d0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
